// File: rtl/high_counter_window_if.sv
// Control and result bundle for high_counter_window: measurement controls and
// per-channel inputs toward the counter, window results back out.
interface high_counter_window_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
);
    logic                      start;
    logic                      continuous;
    logic                      edge_mode;
    logic [CHANNELS-1:0]       in;
    logic [CHANNELS*WIDTH-1:0] count;
    logic                      valid;
    logic                      busy;
    logic [CHANNELS-1:0]       overflow;

    modport master (
        output start, continuous, edge_mode, in,
        input  count, valid, busy, overflow
    );

    modport slave (
        input  start, continuous, edge_mode, in,
        output count, valid, busy, overflow
    );
endinterface

// File: rtl/high_counter_window.sv
// Per-channel high-cycle / rising-edge counter over a fixed window of WINDOW samples.
// Optional HIGH_COUNTER_WINDOW_SAT_EN: accumulators saturate instead of wrapping.
//
// state   | meaning
// IDLE    | waiting for start, outputs hold last result
// MEASURE | sampling one cycle per edge, window counter running down
module high_counter_window #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int WINDOW   = 100
) (
    input  logic               clk,
    input  logic               rst,
    high_counter_window_if.slave bus
);
    localparam int             CW       = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CW-1:0]  WIN_LOAD = CW'(WINDOW - 1);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t                    state;
    logic [WIDTH-1:0]          acc      [CHANNELS];
    logic [WIDTH-1:0]          acc_next [CHANNELS];
    logic [CHANNELS-1:0]       ovf_acc;
    logic [CHANNELS-1:0]       ovf_next;
    logic [CHANNELS-1:0]       hit;
    logic [CHANNELS-1:0]       in_d;
    logic [CW-1:0]             win_cnt;
    logic                      mode_q;
    logic                      valid_q;
    logic                      busy_q;
    logic [CHANNELS*WIDTH-1:0] count_q;
    logic [CHANNELS-1:0]       overflow_q;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            hit[i]      = bus.in[i] & (~mode_q | ~in_d[i]);
            ovf_next[i] = ovf_acc[i] | (hit[i] & (&acc[i]));
`ifdef HIGH_COUNTER_WINDOW_SAT_EN
            acc_next[i] = (hit[i] && !(&acc[i])) ? acc[i] + WIDTH'(1) : acc[i];
`else
            acc_next[i] = acc[i] + WIDTH'(hit[i]);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
            ovf_acc    <= '0;
            in_d       <= '0;
            win_cnt    <= '0;
            mode_q     <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            count_q    <= '0;
            overflow_q <= '0;
        end else begin
            // Previous-value register runs in every state so edge detection is
            // correct on the very first sample of a window.
            in_d    <= bus.in;
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= MEASURE;
                        busy_q  <= 1'b1;
                        for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
                        ovf_acc <= '0;
                        win_cnt <= WIN_LOAD;
                        mode_q  <= bus.edge_mode;
                    end
                end
                MEASURE: begin
                    if (win_cnt == '0) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            count_q[i*WIDTH +: WIDTH] <= acc_next[i];
                            acc[i]                    <= '0;
                        end
                        overflow_q <= ovf_next;
                        valid_q    <= 1'b1;
                        ovf_acc    <= '0;
                        win_cnt    <= WIN_LOAD;
                        // A continuous restart is a new window, so edge_mode is re-latched.
                        mode_q     <= bus.edge_mode;
                        if (!bus.continuous) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        for (int i = 0; i < CHANNELS; i++) acc[i] <= acc_next[i];
                        ovf_acc <= ovf_next;
                        win_cnt <= win_cnt - CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count    = count_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_high_counter_window.sv
// Directed bench for high_counter_window: default-size instance plus a
// WIDTH=4/WINDOW=20 instance for overflow behaviour.
module tb_high_counter_window;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    high_counter_window_if #(.WIDTH(32), .CHANNELS(4)) b1 ();
    high_counter_window_if #(.WIDTH(4),  .CHANNELS(4)) b2 ();

    high_counter_window #(.WIDTH(32), .CHANNELS(4), .WINDOW(100)) dut1 (
        .clk(clk), .rst(rst), .bus(b1.slave)
    );
    high_counter_window #(.WIDTH(4), .CHANNELS(4), .WINDOW(20)) dut2 (
        .clk(clk), .rst(rst), .bus(b2.slave)
    );

`ifdef HIGH_COUNTER_WINDOW_SAT_EN
    localparam logic [3:0] EXP_OVF_CNT = 4'd15;
`else
    localparam logic [3:0] EXP_OVF_CNT = 4'd4;
`endif

    // ch0 high, ch1 toggles, ch2 low, ch3 toggles every 4 cycles (48 highs in samples 1..100)
    function automatic logic [3:0] pat_level(input int k);
        logic [3:0] v;
        v[0] = 1'b1;
        v[1] = (k % 2) == 1;
        v[2] = 1'b0;
        v[3] = (((k + 7) / 4) % 2) == 1;
        return v;
    endfunction

    // ch0 period 4 (2 high / 2 low), ch1 constant high
    function automatic logic [3:0] pat_edge(input int k);
        logic [3:0] v;
        v    = 4'b0000;
        v[0] = (k % 4) < 2;
        v[1] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        for (int c = 0; c < 5; c++) begin
            b1.in = 4'($urandom); b1.start = 1'($urandom);
            b2.in = 4'($urandom); b2.start = 1'($urandom);
            #1;
            n_tests++;
            if (b1.count !== 128'd0) begin n_fail++; $display("FAIL reset_count got %0h exp 0", b1.count); end
            n_tests++;
            if (b1.valid !== 1'b0 || b1.busy !== 1'b0) begin
                n_fail++; $display("FAIL reset_valid_busy got %b%b exp 00", b1.valid, b1.busy);
            end
            n_tests++;
            if (b1.overflow !== 4'd0 || b2.overflow !== 4'd0 || b2.busy !== 1'b0) begin
                n_fail++; $display("FAIL reset_ovf got %b/%b exp 0/0", b1.overflow, b2.overflow);
            end
            @(negedge clk);
        end
        b1.start = 1'b0; b1.in = '0; b2.start = 1'b0; b2.in = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_level();
        int bad_busy = 0;
        int early_valid = 0;
        b1.edge_mode = 1'b0; b1.continuous = 1'b0;
        b1.in = pat_level(0); b1.start = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (b1.busy !== 1'b1) bad_busy++;
            if (b1.valid !== 1'b0) early_valid++;
            b1.in = pat_level(k);
            @(negedge clk);
        end
        n_tests++;
        if (bad_busy != 0) begin n_fail++; $display("FAIL level_busy got %0d low cycles exp 0", bad_busy); end
        n_tests++;
        if (early_valid != 0) begin n_fail++; $display("FAIL level_early_valid got %0d exp 0", early_valid); end
        n_tests++;
        if (b1.valid !== 1'b1) begin n_fail++; $display("FAIL level_valid got %b exp 1", b1.valid); end
        n_tests++;
        if (b1.busy !== 1'b0) begin n_fail++; $display("FAIL level_busy_end got %b exp 0", b1.busy); end
        n_tests++;
        if (b1.count[31:0] !== 32'd100) begin n_fail++; $display("FAIL level_ch0 got %0d exp 100", b1.count[31:0]); end
        n_tests++;
        if (b1.count[63:32] !== 32'd50) begin n_fail++; $display("FAIL level_ch1 got %0d exp 50", b1.count[63:32]); end
        n_tests++;
        if (b1.count[95:64] !== 32'd0) begin n_fail++; $display("FAIL level_ch2 got %0d exp 0", b1.count[95:64]); end
        n_tests++;
        if (b1.count[127:96] !== 32'd48) begin n_fail++; $display("FAIL level_ch3 got %0d exp 48", b1.count[127:96]); end
        n_tests++;
        if (b1.overflow !== 4'd0) begin n_fail++; $display("FAIL level_ovf got %b exp 0000", b1.overflow); end
        b1.in = '0;
        @(negedge clk);
        n_tests++;
        if (b1.valid !== 1'b0) begin n_fail++; $display("FAIL level_valid_pulse got %b exp 0", b1.valid); end
        n_tests++;
        if (b1.count[31:0] !== 32'd100) begin n_fail++; $display("FAIL level_hold got %0d exp 100", b1.count[31:0]); end
    endtask

    task automatic test_edge();
        b1.edge_mode = 1'b1; b1.continuous = 1'b0;
        b1.in = pat_edge(0); b1.start = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            // Mid-window edge_mode change and start pulse must both be ignored.
            b1.edge_mode = (k < 50);
            b1.start     = (k == 50);
            b1.in = pat_edge(k);
            @(negedge clk);
        end
        b1.start = 1'b0;
        n_tests++;
        if (b1.valid !== 1'b1) begin n_fail++; $display("FAIL edge_valid got %b exp 1", b1.valid); end
        n_tests++;
        if (b1.count[31:0] !== 32'd25) begin n_fail++; $display("FAIL edge_ch0 got %0d exp 25", b1.count[31:0]); end
        n_tests++;
        if (b1.count[63:32] !== 32'd0) begin n_fail++; $display("FAIL edge_ch1 got %0d exp 0", b1.count[63:32]); end
        b1.in = '0;
        @(negedge clk);
        n_tests++;
        if (b1.busy !== 1'b0) begin n_fail++; $display("FAIL edge_idle got %b exp 0", b1.busy); end
    endtask

    task automatic test_overflow();
        b2.edge_mode = 1'b0; b2.continuous = 1'b0;
        b2.in = 4'b0001; b2.start = 1'b1;
        @(negedge clk);
        b2.start = 1'b0;
        for (int k = 1; k <= 20; k++) @(negedge clk);
        n_tests++;
        if (b2.valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid got %b exp 1", b2.valid); end
        n_tests++;
        if (b2.count[3:0] !== EXP_OVF_CNT) begin n_fail++; $display("FAIL ovf_ch0 got %0d exp %0d", b2.count[3:0], EXP_OVF_CNT); end
        n_tests++;
        if (b2.count[15:4] !== 12'd0) begin n_fail++; $display("FAIL ovf_others got %0h exp 0", b2.count[15:4]); end
        n_tests++;
        if (b2.overflow !== 4'b0001) begin n_fail++; $display("FAIL ovf_flags got %b exp 0001", b2.overflow); end
        b2.in = '0;
        @(negedge clk);
    endtask

    task automatic test_continuous();
        int bad_valid = 0;
        int bad_cnt = 0;
        int bad_busy = 0;
        int nvalid = 0;
        bit exp_v;
        b1.edge_mode = 1'b0; b1.continuous = 1'b1;
        b1.in = 4'b0001; b1.start = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        for (int t = 1; t <= 400; t++) begin
            exp_v = (t == 101) || (t == 201) || (t == 301);
            if (b1.valid !== exp_v) bad_valid++;
            if (b1.valid === 1'b1) begin
                nvalid++;
                if (b1.count[31:0] !== 32'd100) bad_cnt++;
            end
            if (b1.busy !== (t <= 300)) bad_busy++;
            if (t == 250) b1.continuous = 1'b0;
            @(negedge clk);
        end
        n_tests++;
        if (bad_valid != 0) begin n_fail++; $display("FAIL cont_valid_timing got %0d bad cycles exp 0", bad_valid); end
        n_tests++;
        if (nvalid != 3) begin n_fail++; $display("FAIL cont_valid_count got %0d exp 3", nvalid); end
        n_tests++;
        if (bad_cnt != 0) begin n_fail++; $display("FAIL cont_count got %0d bad windows exp 0", bad_cnt); end
        n_tests++;
        if (bad_busy != 0) begin n_fail++; $display("FAIL cont_busy got %0d bad cycles exp 0", bad_busy); end
        b1.in = '0;
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        b1.edge_mode = 1'b0; b1.continuous = 1'b0;
        b1.in = 4'b0001; b1.start = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        for (int k = 1; k < 50; k++) @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (b1.busy !== 1'b0 || b1.valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_flags got %b%b exp 00", b1.busy, b1.valid);
        end
        n_tests++;
        if (b1.count !== 128'd0) begin n_fail++; $display("FAIL mid_rst_count got %0h exp 0", b1.count); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (b1.valid !== 1'b0 || b1.busy !== 1'b0) bad++;
        end
        rst = 1'b1;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (b1.valid !== 1'b0 || b1.busy !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL mid_rst_quiet got %0d bad cycles exp 0", bad); end
        b1.start = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        bad = 0;
        for (int k = 1; k <= 100; k++) begin
            if (b1.valid !== 1'b0 || b1.busy !== 1'b1) bad++;
            @(negedge clk);
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL mid_rst_window got %0d bad cycles exp 0", bad); end
        n_tests++;
        if (b1.valid !== 1'b1 || b1.count[31:0] !== 32'd100) begin
            n_fail++; $display("FAIL mid_rst_result got valid=%b cnt=%0d exp 1/100", b1.valid, b1.count[31:0]);
        end
        b1.in = '0;
        @(negedge clk);
    endtask

    initial begin
        b1.start = 1'b0; b1.continuous = 1'b0; b1.edge_mode = 1'b0; b1.in = '0;
        b2.start = 1'b0; b2.continuous = 1'b0; b2.edge_mode = 1'b0; b2.in = '0;
        @(negedge clk);
        test_reset();
        test_level();
        test_edge();
        test_overflow();
        test_continuous();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
